// File: rtl/real_sweep_gen_if.sv
// Stream and control bundle of the triangle sweep source.
// The generator drives samples and status; the consumer drives commands and ready.
interface real_sweep_gen_if #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
);
    logic                 start;
    logic                 stop;
    logic [WIDTH-2:0]     step;
    logic [CNT_WIDTH-1:0] num_samples;
    logic [WIDTH-1:0]     out;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;
    logic                 done;

    modport master (
        input  start, stop, step, num_samples, out_ready,
        output out, out_valid, busy, done
    );

    modport slave (
        output start, stop, step, num_samples, out_ready,
        input  out, out_valid, busy, done
    );
endinterface

// File: rtl/real_sweep_gen.sv
// Bounded triangle sweep of signed fixed-point codes on a valid/ready stream.
// Every emitted code stays inside +/-LIMIT, the code form of the real range.
module real_sweep_gen #(
    parameter int  WIDTH     = 16,
    parameter int  EXPONENT  = -8,
    parameter real RANGE     = 10.0,
    parameter int  CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    real_sweep_gen_if.master       bus
);
    localparam real SCALED   = RANGE * (2.0 ** (-EXPONENT));
    localparam int  MAX_CODE = (2 ** (WIDTH - 1)) - 1;
    localparam int  LIMIT    = (SCALED >= real'(MAX_CODE)) ? MAX_CODE : $rtoi(SCALED);

    localparam logic signed [WIDTH:0] LIM_POS = (WIDTH + 1)'(LIMIT);
    localparam logic signed [WIDTH:0] LIM_NEG = -LIM_POS;

    typedef enum logic [1:0] {
        IDLE,
        RUN_UP,
        RUN_DOWN
    } state_t;

    state_t                   state_reg, state_next;
    logic signed [WIDTH-1:0]  out_reg, out_next;
    logic                     valid_reg, valid_next;
    logic                     done_reg, done_next;
    logic [CNT_WIDTH-1:0]     count_reg, count_next;
    logic [CNT_WIDTH-1:0]     num_reg, num_next;
    logic [WIDTH-2:0]         step_reg, step_next;

    logic signed [WIDTH:0]    out_ext;
    logic signed [WIDTH:0]    step_ext;
    logic signed [WIDTH:0]    sum_up;
    logic signed [WIDTH:0]    sum_down;
    logic [CNT_WIDTH-1:0]     count_inc;

    // One extra bit so the step can overshoot the limit without wrapping.
    assign out_ext   = {out_reg[WIDTH-1], out_reg};
    assign step_ext  = {2'b00, step_reg};
    assign sum_up    = out_ext + step_ext;
    assign sum_down  = out_ext - step_ext;
    assign count_inc = count_reg + CNT_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            out_reg   <= '0;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
            count_reg <= '0;
            num_reg   <= '0;
            step_reg  <= '0;
        end else begin
            state_reg <= state_next;
            out_reg   <= out_next;
            valid_reg <= valid_next;
            done_reg  <= done_next;
            count_reg <= count_next;
            num_reg   <= num_next;
            step_reg  <= step_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        out_next   = out_reg;
        valid_next = valid_reg;
        done_next  = 1'b0;
        count_next = count_reg;
        num_next   = num_reg;
        step_next  = step_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    step_next  = bus.step;
                    num_next   = bus.num_samples;
                    count_next = '0;
                    if (bus.num_samples == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = RUN_UP;
                        out_next   = '0;
                        valid_next = 1'b1;
                    end
                end
            end
            RUN_UP, RUN_DOWN: begin
                // stop overrides a handshake landing on the same edge
                if (bus.stop) begin
                    state_next = IDLE;
                    out_next   = '0;
                    valid_next = 1'b0;
                    count_next = '0;
                end else if (valid_reg && bus.out_ready) begin
                    if (count_inc == num_reg) begin
                        state_next = IDLE;
                        out_next   = '0;
                        valid_next = 1'b0;
                        done_next  = 1'b1;
                        count_next = '0;
                    end else begin
                        count_next = count_inc;
                        if (state_reg == RUN_UP) begin
                            if (sum_up >= LIM_POS) begin
                                out_next   = LIM_POS[WIDTH-1:0];
                                state_next = RUN_DOWN;
                            end else begin
                                out_next = sum_up[WIDTH-1:0];
                            end
                        end else begin
                            if (sum_down <= LIM_NEG) begin
                                out_next   = LIM_NEG[WIDTH-1:0];
                                state_next = RUN_UP;
                            end else begin
                                out_next = sum_down[WIDTH-1:0];
                            end
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
                out_next   = '0;
                valid_next = 1'b0;
            end
        endcase
    end

    assign bus.out       = out_reg;
    assign bus.out_valid = valid_reg;
    assign bus.busy      = (state_reg != IDLE);
    assign bus.done      = done_reg;
endmodule

// File: tb/tb_real_sweep_gen.sv
// Directed bench for real_sweep_gen: two instances, LIMIT=32 (a) and LIMIT=127 (b).
module tb_real_sweep_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    real_sweep_gen_if #(.WIDTH(8), .CNT_WIDTH(16)) ia ();
    real_sweep_gen_if #(.WIDTH(8), .CNT_WIDTH(16)) ib ();

    real_sweep_gen #(.WIDTH(8), .EXPONENT(-4), .RANGE(2.0), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ia.master)
    );
    real_sweep_gen #(.WIDTH(8), .EXPONENT(-4), .RANGE(100.0), .CNT_WIDTH(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ib.master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int basic_exp [14] = '{0, 10, 20, 30, 32, 22, 12, 2, -8, -18, -28, -32, -22, -12};
    int clamp_exp [5]  = '{0, 127, 0, -127, 0};

    int qa[$];
    int qb[$];
    int da = 0;
    int db = 0;
    bit hold_a = 0;
    int prev_a = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Handshakes and done pulses are observed mid-cycle, when inputs and outputs are settled.
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_a) begin
                check("hold_valid_a", int'(ia.out_valid), 1);
                check("hold_out_a", int'($signed(ia.out)), prev_a);
            end
            if (ia.out_valid && ia.out_ready) begin
                qa.push_back(int'($signed(ia.out)));
                $display("a sample %0d", $signed(ia.out));
            end
            if (ib.out_valid && ib.out_ready) begin
                qb.push_back(int'($signed(ib.out)));
                $display("b sample %0d", $signed(ib.out));
            end
            if (ia.done) da++;
            if (ib.done) db++;
            hold_a = ia.out_valid && !ia.out_ready;
            prev_a = int'($signed(ia.out));
        end else begin
            hold_a = 0;
        end
    end

    task automatic start_a(input int stp, input int n);
        ia.step        = 7'(stp);
        ia.num_samples = 16'(n);
        ia.start       = 1'b1;
        @(posedge clk); #1;
        ia.start = 1'b0;
    endtask

    task automatic wait_done_a(input int bound, input bit bp);
        bit seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(posedge clk); #1;
            if (ia.done) begin
                seen = 1;
                check("end_valid_a", int'(ia.out_valid), 0);
                check("end_busy_a", int'(ia.busy), 0);
            end else if (bp) begin
                ia.out_ready = 1'($urandom_range(0, 1));
            end
        end
        check("done_seen_a", int'(seen), 1);
        ia.out_ready = 1'b1;
        @(posedge clk); #1;
        check("done_drop_a", int'(ia.done), 0);
    endtask

    task automatic compare_basic(input string tag);
        check({tag, "_len"}, qa.size(), 14);
        for (int i = 0; i < 14; i++)
            check($sformatf("%s[%0d]", tag, i), (i < qa.size()) ? qa[i] : 32'h7fff_ffff, basic_exp[i]);
    endtask

    initial begin
        int d0;
        ia.start = 0; ia.stop = 0; ia.step = '0; ia.num_samples = '0; ia.out_ready = 1;
        ib.start = 0; ib.stop = 0; ib.step = '0; ib.num_samples = '0; ib.out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", int'($signed(ia.out)), 0);
        check("rst_valid", int'(ia.out_valid), 0);
        check("rst_busy", int'(ia.busy), 0);
        check("rst_done", int'(ia.done), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic sweep
        qa.delete(); d0 = da;
        start_a(10, 14);
        check("start_valid", int'(ia.out_valid), 1);
        check("start_out", int'($signed(ia.out)), 0);
        check("start_busy", int'(ia.busy), 1);
        wait_done_a(100, 0);
        compare_basic("basic");
        check("basic_done_cnt", da - d0, 1);

        // Backpressure
        qa.delete(); d0 = da;
        ia.out_ready = 1'b0;
        start_a(10, 14);
        wait_done_a(400, 1);
        compare_basic("bp");
        check("bp_done_cnt", da - d0, 1);

        // Clamp to width on instance b
        begin
            bit seen = 0;
            qb.delete();
            ib.step = 7'd127; ib.num_samples = 16'd5; ib.start = 1'b1;
            @(posedge clk); #1;
            ib.start = 1'b0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(posedge clk); #1;
                if (ib.done) seen = 1;
            end
            check("clamp_done", int'(seen), 1);
            check("clamp_len", qb.size(), 5);
            for (int i = 0; i < 5; i++)
                check($sformatf("clamp[%0d]", i), (i < qb.size()) ? qb[i] : 32'h7fff_ffff, clamp_exp[i]);
        end

        // Zero length
        qa.delete();
        start_a(10, 0);
        check("zlen_done", int'(ia.done), 1);
        check("zlen_busy", int'(ia.busy), 0);
        check("zlen_valid", int'(ia.out_valid), 0);
        @(posedge clk); #1;
        check("zlen_drop", int'(ia.done), 0);
        check("zlen_samples", qa.size(), 0);

        // Zero step
        qa.delete();
        start_a(0, 3);
        wait_done_a(50, 0);
        check("zstep_len", qa.size(), 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("zstep[%0d]", i), (i < qa.size()) ? qa[i] : 32'h7fff_ffff, 0);

        // Abort on the 4th handshake
        d0 = da;
        start_a(10, 14);
        repeat (3) @(posedge clk);
        #1;
        ia.stop = 1'b1;
        @(posedge clk); #1;
        ia.stop = 1'b0;
        check("abort_valid", int'(ia.out_valid), 0);
        check("abort_busy", int'(ia.busy), 0);
        check("abort_done", int'(ia.done), 0);
        @(posedge clk); #1;
        check("abort_done2", da - d0, 0);
        qa.delete(); d0 = da;
        start_a(10, 14);
        check("restart_out", int'($signed(ia.out)), 0);
        wait_done_a(100, 0);
        compare_basic("restart");
        check("restart_done_cnt", da - d0, 1);

        // Asynchronous reset during RUN_DOWN
        start_a(10, 14);
        repeat (7) @(posedge clk);
        @(negedge clk); #2;
        check("pre_rst_busy", int'(ia.busy), 1);
        rst_n = 1'b0;
        #1;
        check("arst_out", int'($signed(ia.out)), 0);
        check("arst_valid", int'(ia.out_valid), 0);
        check("arst_busy", int'(ia.busy), 0);
        check("arst_done", int'(ia.done), 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_valid", int'(ia.out_valid), 0);
        check("post_rst_busy", int'(ia.busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/real_sweep_gen.md
# real_sweep_gen

Stimulus source for fixed-point real signals. It emits a bounded triangle sweep of sample codes on a valid/ready stream. Every emitted value lies inside the symmetric range ±RANGE, so it never trips a downstream range assertion. It sits in testbenches and self-test paths ahead of blocks whose real-valued inputs are range-checked, and it exercises the full declared range including both endpoints.

## Interface
- WIDTH, 16, bit width of the signed fixed-point output code
- EXPONENT, -8, binary exponent: real value = out × 2^EXPONENT
- RANGE, 10.0, real magnitude bound; LIMIT = min(floor(RANGE / 2^EXPONENT), 2^(WIDTH-1)-1), computed at elaboration
- CNT_WIDTH, 16, width of the sample counter
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  begins a sweep when sampled high in IDLE
- stop  input  1  aborts a sweep in progress
- step  input  WIDTH-1  unsigned increment code, sampled on accepted start
- num_samples  input  CNT_WIDTH  samples per sweep, sampled on accepted start
- out  output  WIDTH  signed sample code
- out_valid  output  1  out holds a sample
- out_ready  input  1  consumer accepts the sample
- busy  output  1  high in RUN_UP or RUN_DOWN
- done  output  1  one-cycle pulse when a sweep completes normally

## Operation
- States: IDLE, RUN_UP, RUN_DOWN.
- Reset values: state IDLE, out=0, out_valid=0, busy=0, done=0, counter=0, latched step=0.
- IDLE with start=1:
  - Latch step and num_samples.
  - If num_samples=0, stay in IDLE and pulse done next cycle; no sample is emitted.
  - Otherwise go to RUN_UP with out=0 and out_valid=1.
- Accepted sample: out_valid & out_ready at a rising edge. The counter increments on each one.
- If the accepted sample brings the count to num_samples: go to IDLE, out_valid=0, out=0, and done=1 for one cycle.
- Otherwise, compute the next value in WIDTH+1-bit signed arithmetic (no wrap):
  - RUN_UP: n = out + step. If n ≥ LIMIT, out = LIMIT and go to RUN_DOWN; else out = n.
  - RUN_DOWN: n = out − step. If n ≤ −LIMIT, out = −LIMIT and go to RUN_UP; else out = n.
- step=0: out holds 0 for every sample; the sweep ends after num_samples samples.
- Outputs are stable while valid and not ready: out and out_valid do not change while out_valid=1 and out_ready=0.
- stop=1 while busy:
  - Next cycle: IDLE, out_valid=0, out=0, counter cleared, no done pulse.
  - stop has priority over a simultaneous handshake.
  - stop in IDLE is ignored.
- start while busy is ignored. start and stop high together in IDLE: start wins.
- rst_n low at any time forces the reset values immediately. No partial sweep resumes after rst_n is released.
- Invariant: −LIMIT ≤ out ≤ LIMIT at all times.

## Timing
- Start sampled at edge N → out_valid=1, out=0, busy=1 after edge N.
- Throughput is 1 sample/cycle with out_ready held high. The next value appears the cycle after each handshake.
- Final handshake at edge M → after edge M: out_valid=0, busy=0, done=1. done drops after edge M+1.
- A new start is accepted at edge M+1 at the earliest.
- num_samples=0: start at edge N → done=1 after edge N for one cycle; busy stays 0.
- stop sampled at edge K → out_valid=0 and busy=0 after edge K.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Basic sweep. Setup: WIDTH=8, EXPONENT=-4, RANGE=2.0, so LIMIT=32; step=10, num_samples=14, out_ready=1.
  - Required out sequence: 0, 10, 20, 30, 32, 22, 12, 2, −8, −18, −28, −32, −22, −12.
  - done pulses once, one cycle after the −12 handshake.
- Backpressure. Same setup; toggle out_ready pseudo-randomly.
  - The same 14-value sequence is produced.
  - out stays unchanged during every valid-not-ready cycle; there are no duplicates and no drops.
- LIMIT clamp to width. Setup: WIDTH=8, EXPONENT=-4, RANGE=100.0, so LIMIT=127; step=127, num_samples=5.
  - Required out sequence: 0, 127, 0, −127, 0.
- Zero length and zero step.
  - num_samples=0 → done pulse after 1 cycle, out_valid never high.
  - step=0, num_samples=3 → three samples of value 0.
- Abort. Assert stop in the same cycle as the 4th handshake of the basic sweep.
  - out_valid=0 and busy=0 next cycle, with no done.
  - A following start restarts the sweep at 0.
- Reset mid-sweep. Pull rst_n low asynchronously between clock edges during RUN_DOWN.
  - All outputs go to their reset values immediately.
  - After release, the block sits in IDLE until start.
